// File: rtl/cpu_clock_control.sv
// CPU clock-enable generator: free-run divider, paused single-step from a push-button.
// Define CPU_CLOCK_CONTROL_DEBOUNCE_EN to filter the step key through a stable-count debouncer.
module cpu_clock_control #(
    parameter int DIV_WIDTH       = 26,
    parameter int CNT_WIDTH       = 32,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 run,
    input  logic [DIV_WIDTH-1:0] divisor,
    input  logic                 step_key_n,
    output logic                 cpu_tick,
    output logic                 beat,
    output logic                 running,
    output logic [CNT_WIDTH-1:0] tick_count
);

    typedef enum logic [1:0] {PAUSE, RUN, STEP} state_t;

    state_t               state;
    logic [DIV_WIDTH-1:0] cnt;

    logic       key_s1, key_s2, key_filt, key_prev, armed, press;
    logic [1:0] sync_vld;

    // armed stays low until the synchronized key has been seen released after
    // reset, so a key held through reset cannot masquerade as a fresh press.
    always_ff @(posedge clock) begin
        if (reset) begin
            key_s1   <= 1'b1;
            key_s2   <= 1'b1;
            key_prev <= 1'b1;
            sync_vld <= 2'b00;
            armed    <= 1'b0;
        end else begin
            key_s1   <= step_key_n;
            key_s2   <= key_s1;
            key_prev <= key_filt;
            sync_vld <= {sync_vld[0], 1'b1};
            armed    <= armed | (sync_vld[1] & key_s2);
        end
    end

`ifdef CPU_CLOCK_CONTROL_DEBOUNCE_EN
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    logic [DB_W-1:0] db_cnt;

    // Count consecutive samples that disagree with the filtered value.
    always_ff @(posedge clock) begin
        if (reset) begin
            key_filt <= 1'b1;
            db_cnt   <= '0;
        end else if (key_s2 == key_filt) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            key_filt <= key_s2;
            db_cnt   <= '0;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end
`else
    assign key_filt = key_s2;
`endif

    assign press = armed & key_prev & ~key_filt;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= PAUSE;
            cnt        <= '0;
            cpu_tick   <= 1'b0;
            beat       <= 1'b0;
            running    <= 1'b0;
            tick_count <= '0;
        end else begin
            cpu_tick <= 1'b0;
            case (state)
                PAUSE: begin
                    cnt <= '0;
                    // run has priority over a simultaneous press
                    if (run) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end else if (press) begin
                        state      <= STEP;
                        cpu_tick   <= 1'b1;
                        beat       <= ~beat;
                        tick_count <= tick_count + CNT_WIDTH'(1);
                    end
                end
                RUN: begin
                    if (!run) begin
                        state   <= PAUSE;
                        running <= 1'b0;
                        cnt     <= '0;
                    end else if (cnt >= divisor) begin
                        cnt        <= '0;
                        cpu_tick   <= 1'b1;
                        beat       <= ~beat;
                        tick_count <= tick_count + CNT_WIDTH'(1);
                    end else begin
                        cnt <= cnt + DIV_WIDTH'(1);
                    end
                end
                STEP: begin
                    cnt     <= '0;
                    state   <= run ? RUN : PAUSE;
                    running <= run;
                end
                default: begin
                    cnt     <= '0;
                    state   <= PAUSE;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_clock_control.sv
// Directed bench for cpu_clock_control: divider timing, live divisor, step key, reset and wrap.
module tb_cpu_clock_control;

    localparam int DIV_WIDTH = 8;
    localparam int CNT_WIDTH = 4;
    localparam int DEB       = 8;
`ifdef CPU_CLOCK_CONTROL_DEBOUNCE_EN
    localparam int KEY_LAT = 3 + DEB;
`else
    localparam int KEY_LAT = 3;
`endif

    logic                 clock = 1'b0;
    logic                 reset, run, step_key_n;
    logic [DIV_WIDTH-1:0] divisor;
    logic                 cpu_tick, beat, running;
    logic [CNT_WIDTH-1:0] tick_count;

    int vectors = 0;
    int errors  = 0;
    int k;

    always #5 clock = ~clock;

    cpu_clock_control #(
        .DIV_WIDTH(DIV_WIDTH), .CNT_WIDTH(CNT_WIDTH), .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clock(clock), .reset(reset), .run(run), .divisor(divisor),
        .step_key_n(step_key_n), .cpu_tick(cpu_tick), .beat(beat),
        .running(running), .tick_count(tick_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Advance n cycles, returning the number of cpu_tick pulses seen.
    task automatic cyc_count(input int n, output int ticks);
        ticks = 0;
        repeat (n) begin
            @(posedge clock);
            #1;
            ticks += int'(cpu_tick);
        end
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; step_key_n = 1'b1; divisor = 8'd3;
        cyc(2);
        chk("rst_tick", 32'(cpu_tick), 0);
        chk("rst_beat", 32'(beat), 0);
        chk("rst_running", 32'(running), 0);
        chk("rst_count", 32'(tick_count), 0);

        // divisor=3: first tick 4 cycles after run sampled, then every 4th
        reset = 1'b0; run = 1'b1;
        cyc(1);
        chk("run_entry_running", 32'(running), 1);
        chk("run_entry_tick", 32'(cpu_tick), 0);
        cyc_count(3, k);
        chk("div3_first_gap", 32'(k), 0);
        cyc(1);
        chk("div3_first_tick", 32'(cpu_tick), 1);
        for (int p = 2; p <= 10; p++) begin
            cyc_count(3, k);
            chk("div3_gap", 32'(k), 0);
            cyc(1);
            chk("div3_tick", 32'(cpu_tick), 1);
        end
        chk("div3_count10", 32'(tick_count), 10);
        chk("div3_beat", 32'(beat), 0);

        // live divisor lowered below current count
        divisor = 8'd9;
        cyc_count(7, k);
        chk("div9_upto7", 32'(k), 0);
        divisor = 8'd2;
        cyc(1);
        chk("div_lower_tick", 32'(cpu_tick), 1);
        cyc_count(2, k);
        chk("div2_gap_a", 32'(k), 0);
        cyc(1);
        chk("div2_tick_a", 32'(cpu_tick), 1);
        cyc_count(2, k);
        chk("div2_gap_b", 32'(k), 0);
        cyc(1);
        chk("div2_tick_b", 32'(cpu_tick), 1);
        chk("div2_count", 32'(tick_count), 13);

        // drop run with counter already at divisor: no tick
        divisor = 8'd5;
        cyc_count(5, k);
        chk("div5_upto5", 32'(k), 0);
        run = 1'b0;
        cyc(1);
        chk("stop_no_tick", 32'(cpu_tick), 0);
        chk("stop_running", 32'(running), 0);

        // key pressed while running must not queue a step
        divisor = 8'd200; run = 1'b1;
        cyc(2);
        step_key_n = 1'b0;
        cyc_count(30, k);
        chk("run_key_ignored", 32'(k), 0);
        run = 1'b0;
        cyc_count(30, k);
        chk("run_key_no_queue", 32'(k), 0);
        chk("run_key_count", 32'(tick_count), 13);
        step_key_n = 1'b1;
        cyc(20);

        // single step: held key gives exactly one tick
        step_key_n = 1'b0;
        cyc_count(KEY_LAT - 1, k);
        chk("step_latency_early", 32'(k), 0);
        cyc(1);
        chk("step_tick", 32'(cpu_tick), 1);
        cyc_count(100, k);
        chk("step_hold_once", 32'(k), 0);
        chk("step_count1", 32'(tick_count), 14);
        step_key_n = 1'b1;
        cyc(20);
        step_key_n = 1'b0;
        cyc_count(KEY_LAT + 5, k);
        chk("step_second", 32'(k), 1);
        chk("step_count2", 32'(tick_count), 15);
        step_key_n = 1'b1;
        cyc(20);

        // press edge and run rising on the same cycle: run wins
        step_key_n = 1'b0;
        cyc(KEY_LAT - 1);
        run = 1'b1;
        cyc(1);
        chk("race_running", 32'(running), 1);
        chk("race_no_tick", 32'(cpu_tick), 0);
        cyc_count(10, k);
        chk("race_quiet", 32'(k), 0);
        run = 1'b0; step_key_n = 1'b1;
        cyc(20);

        // key held low through reset
        step_key_n = 1'b0; reset = 1'b1;
        cyc(3);
        reset = 1'b0;
        cyc(1);
        chk("post_rst_tick", 32'(cpu_tick), 0);
        chk("post_rst_count", 32'(tick_count), 0);
        cyc_count(30, k);
        chk("held_rst_no_step", 32'(k), 0);
        step_key_n = 1'b1;
        cyc(20);
        step_key_n = 1'b0;
        cyc_count(KEY_LAT + 3, k);
        chk("held_rst_repress", 32'(k), 1);
        step_key_n = 1'b1;

        // divisor=0 every cycle, 4-bit tick_count wraps
        reset = 1'b1;
        cyc(2);
        reset = 1'b0; divisor = 8'd0; run = 1'b1;
        cyc(1);
        chk("div0_entry_tick", 32'(cpu_tick), 0);
        cyc_count(17, k);
        chk("div0_every_cycle", 32'(k), 17);
        chk("wrap_count", 32'(tick_count), 1);
        chk("wrap_beat", 32'(beat), 1);
        reset = 1'b1;
        cyc(1);
        chk("midrun_rst_tick", 32'(cpu_tick), 0);
        chk("midrun_rst_beat", 32'(beat), 0);
        chk("midrun_rst_running", 32'(running), 0);
        chk("midrun_rst_count", 32'(tick_count), 0);
        reset = 1'b0;
        cyc(1);
        chk("after_rst_no_tick", 32'(cpu_tick), 0);
        chk("after_rst_running", 32'(running), 1);
        run = 1'b0;
        cyc(5);

`ifdef CPU_CLOCK_CONTROL_DEBOUNCE_EN
        // bouncing key: short low pulses are filtered, one step total
        begin
            int total;
            total = 0;
            for (int b = 0; b < 3; b++) begin
                step_key_n = 1'b0;
                cyc_count(3, k);
                total += k;
                step_key_n = 1'b1;
                cyc_count(3, k);
                total += k;
            end
            step_key_n = 1'b0;
            cyc_count(20, k);
            total += k;
            chk("debounce_one_step", 32'(total), 1);
            step_key_n = 1'b1;
            cyc(20);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/cpu_clock_control.md
CPU_CLOCK_CONTROL -- requirements
Module: cpu_clock_control

Interface
REQ-001 SHALL have parameter DIV_WIDTH, default 26, width of the divide counter and divisor input.
REQ-002 SHALL have parameter CNT_WIDTH, default 32, width of tick_count.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 500000, stable-cycle count for step_key_n (10 ms at 50 MHz).
REQ-004 SHALL have port: clock  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port: run  input  1  level; 1 = free-run mode, 0 = paused/single-step mode.
REQ-007 SHALL have port: divisor  input  DIV_WIDTH  tick period minus one, in clock cycles.
REQ-008 SHALL have port: step_key_n  input  1  raw asynchronous push-button, active-low.
REQ-009 SHALL have port: cpu_tick  output  1  one-cycle-wide clock-enable pulse for the CPU.
REQ-010 SHALL have port: beat  output  1  toggles on every cpu_tick (LED heartbeat).
REQ-011 SHALL have port: running  output  1  high while FSM is in RUN.
REQ-012 SHALL have port: tick_count  output  CNT_WIDTH  number of cpu_tick pulses since reset.

Function
REQ-013 SHALL implement FSM states PAUSE, RUN, STEP; all outputs registered.
REQ-014 SHALL transition PAUSE->RUN when run=1, RUN->PAUSE when run=0, evaluated every cycle.
REQ-015 In RUN, divide counter SHALL increment each cycle; when counter >= divisor, cpu_tick SHALL assert next cycle and counter SHALL return to 0.
REQ-016 divisor=0 in RUN SHALL yield cpu_tick high every cycle.
REQ-017 divisor SHALL be compared live; lowering divisor below current count SHALL fire a tick on the next comparison (>= rule), never skip to wrap of the counter.
REQ-018 On PAUSE->RUN entry, counter SHALL start at 0; first cpu_tick SHALL occur divisor+1 cycles after the cycle run is sampled high.
REQ-019 On RUN->PAUSE, counter SHALL clear to 0 and no cpu_tick SHALL be issued in the cycle run is sampled low, even if counter >= divisor.
REQ-020 step_key_n SHALL pass a two-flop synchronizer before any use.
REQ-021 In PAUSE, a press (synchronized/filtered 1->0 edge) SHALL move FSM to STEP; STEP SHALL assert cpu_tick for exactly one cycle and return to PAUSE (or RUN if run=1).
REQ-022 Holding the key SHALL produce exactly one step; a new step requires release then press.
REQ-023 Key presses in RUN SHALL be ignored and SHALL NOT queue a step for later PAUSE.
REQ-024 Press edge and run 0->1 in same cycle: run SHALL win; no STEP tick.
REQ-025 tick_count SHALL increment by 1 per cpu_tick, wrapping from 2^CNT_WIDTH-1 to 0.
REQ-026 running SHALL be 1 exactly in cycles where state is RUN.

Reset
REQ-027 On reset=1 at a clock edge: state=PAUSE, counter=0, cpu_tick=0, beat=0, running=0, tick_count=0, synchronizer and debounce state = released (1).
REQ-028 reset mid-count or mid-step SHALL discard pending ticks; no cpu_tick in the cycle after reset deasserts.
REQ-029 A key held low through reset deassertion SHALL NOT produce a step until released and pressed again.

Configuration
REQ-030 Macro CPU_CLOCK_CONTROL_DEBOUNCE_EN defined: synchronized key SHALL update its filtered value only after DEBOUNCE_CYCLES consecutive identical samples; edges detected on the filtered value.
REQ-031 Macro undefined: edge detection SHALL use the synchronized key directly; DEBOUNCE_CYCLES unused; no debounce counter synthesized.

Verification
REQ-032 Reset, run=1, divisor=3 -> cpu_tick every 4th cycle, first 4 cycles after run sampled; after 10 ticks tick_count=10, beat=0.
REQ-033 run=1, divisor=9, at count 7 set divisor=2 -> cpu_tick next cycle, then every 3 cycles.
REQ-034 run=0, key pressed and held 100 cycles (debounce off) -> exactly one cpu_tick 3 cycles after press edge at pin; tick_count=1; second press after release -> tick_count=2.
REQ-035 DEBOUNCE_EN, DEBOUNCE_CYCLES=8, key bounce pulses of 3 cycles then stable low 20 cycles -> exactly one cpu_tick.
REQ-036 run=1, divisor=5, drop run at count 5 -> no cpu_tick, running=0 next cycle; key pressed during RUN then run=0 -> no tick.
REQ-037 tick_count preset path: CNT_WIDTH=4, divisor=0, 17 ticks -> tick_count wraps to 1; reset mid-run -> all outputs 0 next cycle.
